// File: rtl/spi_psram_responder.sv
// SPI mode-0 PSRAM target: 0x02 write / 0x03 read, 24-bit address, 32-bit data, MSB first.
// Latency: SPI lines pass SYNC_STAGES flops plus one edge-detect flop; so follows a synced sck fall.
// No backpressure: the controller owns sck; faster SCK than the oversampling allows is unsupported.
module spi_psram_responder #(
  parameter int AW          = 8,
  parameter bit CS_ACT_HIGH = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sck,
  input  logic          cs,
  input  logic          si,
  output logic          so,
  output logic          wr_done,
  output logic          rd_done,
  output logic          cmd_err,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_rdata
);

  // Fewer than two synchronizer stages is never safe, so clamp it.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WR,
    S_RD,
    S_IGNORE
  } state_t;

  // Synchronizer chains and edge-detect history. Deliberately not reset:
  // reset must not fabricate a select edge while cs is still held active.
  logic [SS-1:0] sck_sync;
  logic [SS-1:0] cs_sync;
  logic [SS-1:0] si_sync;
  logic          sck_prev;
  logic          sel_prev;

  logic          sck_s;
  logic          si_s;
  logic          sel;
  logic          sck_rise;
  logic          sck_fall;

  state_t        state;
  logic [6:0]    cnt;        // rises seen this frame, saturates at 64
  logic [31:0]   shreg;      // shared input shift register for cmd/addr/data
  logic [31:0]   shift_next;
  logic [31:0]   rd_shift;
  logic [5:0]    rd_cnt;     // read bits already presented on so
  logic          is_wr;
  logic [AW-1:0] idx;
  logic          wr_commit;

  logic [31:0]   mem [0:(1<<AW)-1];

  // Bring the asynchronous SPI lines into the clk domain.
  always_ff @(posedge clk) begin
    sck_sync <= {sck_sync[SS-2:0], sck};
    cs_sync  <= {cs_sync[SS-2:0], cs};
    si_sync  <= {si_sync[SS-2:0], si};
    sck_prev <= sck_s;
    sel_prev <= sel;
  end

  assign sck_s      = sck_sync[SS-1];
  assign si_s       = si_sync[SS-1];
  assign sel        = (cs_sync[SS-1] == CS_ACT_HIGH);
  assign sck_rise   = sck_s & ~sck_prev;
  assign sck_fall   = ~sck_s & sck_prev;
  assign shift_next = {shreg[30:0], si_s};

  // A write lands on the 32nd data rise, only while still selected and out of reset.
  assign wr_commit = !reset && sel && (state == S_WR) && sck_rise && (cnt == 7'd63);

  // Protocol FSM: frame decode, bit counting, read serialisation and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 7'd0;
      shreg    <= 32'd0;
      rd_shift <= 32'd0;
      rd_cnt   <= 6'd0;
      is_wr    <= 1'b0;
      idx      <= '0;
      so       <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      wr_done <= wr_commit;
      rd_done <= 1'b0;
      cmd_err <= 1'b0;
      if (!sel) begin
        // Deselect aborts whatever was in flight; a partial write is dropped.
        state  <= S_IDLE;
        cnt    <= 7'd0;
        rd_cnt <= 6'd0;
        so     <= 1'b0;
      end else if (state == S_IDLE) begin
        // Only a fresh select edge opens a frame.
        if (!sel_prev) begin
          state  <= S_CMD;
          cnt    <= 7'd0;
          shreg  <= 32'd0;
          rd_cnt <= 6'd0;
          so     <= 1'b0;
        end
      end else begin
        if (sck_rise) begin
          shreg <= shift_next;
          if (cnt != 7'd64) begin
            cnt <= cnt + 7'd1;
          end
          case (state)
            S_CMD: begin
              if (cnt == 7'd7) begin
                if (shift_next[7:0] == CMD_WRITE) begin
                  is_wr <= 1'b1;
                  state <= S_ADDR;
                end else if (shift_next[7:0] == CMD_READ) begin
                  is_wr <= 1'b0;
                  state <= S_ADDR;
                end else begin
                  cmd_err <= 1'b1;
                  state   <= S_IGNORE;
                end
              end
            end
            S_ADDR: begin
              if (cnt == 7'd31) begin
                // Byte-offset bits and bits above the array are dropped, so addresses alias.
                idx <= shift_next[AW+1:2];
                if (is_wr) begin
                  state <= S_WR;
                end else begin
                  rd_shift <= mem[shift_next[AW+1:2]];
                  rd_cnt   <= 6'd0;
                  state    <= S_RD;
                end
              end
            end
            S_WR: begin
              if (cnt == 7'd63) begin
                state <= S_IGNORE;
              end
            end
            default: begin
            end
          endcase
        end
        if (sck_fall && (state == S_RD)) begin
          if (rd_cnt == 6'd32) begin
            rd_done <= 1'b1;
            so      <= 1'b0;
            state   <= S_IGNORE;
          end else begin
            so       <= rd_shift[31];
            rd_shift <= {rd_shift[30:0], 1'b0};
            rd_cnt   <= rd_cnt + 6'd1;
          end
        end
      end
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[idx] <= shift_next;
    end
  end

  // Debug readback; a same-cycle commit to the same index returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_rdata <= 32'd0;
    end else begin
      dbg_rdata <= mem[dbg_addr];
    end
  end

endmodule
